// File: rtl/alu_seq_exec.sv
// alu_seq_exec: multi-cycle execute-stage ALU feeding the flag register.
// One operation is accepted per start pulse while idle. ADD/SUB/XOR/PADDSB
// and illegal opcodes finish one cycle after accept. Shifts and rotates
// step one bit per cycle. Completion raises done for exactly one cycle,
// together with the Z/N/V values and their per-flag write enables.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, opcode, a, b request and operands (sampled only while idle)
//   busy                operation in flight
//   done                one-cycle completion pulse
//   result              last completed result, held between operations
//   z_out, n_out, v_out flag values, held until their enable pulses
//   en_z, en_n, en_v    one-cycle flag write enables, only with done
module alu_seq_exec #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             z_out,
  output logic             n_out,
  output logic             v_out,
  output logic             en_z,
  output logic             en_n,
  output logic             en_v
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned LANE_W = 4;
  localparam int unsigned LANES  = WIDTH / LANE_W;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [0:0]       state, state_nxt;
  logic [3:0]       op_q, op_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [WIDTH-1:0] acc_q, acc_nxt;
  logic             vpend_q, vpend_nxt;
  logic             done_nxt, en_z_nxt, en_n_nxt, en_v_nxt;
  logic [WIDTH-1:0] result_nxt;
  logic             z_nxt, n_nxt, v_nxt;

  // Sign-extended sum/difference; the extra bit exposes signed overflow.
  logic [WIDTH:0] add_ext, sub_ext;
  logic           add_ovf, sub_ovf;

  assign add_ext = {a[WIDTH-1], a} + {b[WIDTH-1], b};
  assign sub_ext = {a[WIDTH-1], a} - {b[WIDTH-1], b};
  assign add_ovf = add_ext[WIDTH] ^ add_ext[WIDTH-1];
  assign sub_ovf = sub_ext[WIDTH] ^ sub_ext[WIDTH-1];

  assign busy = (state == RUN);

  // Clamp a sign-extended sum: the top bit gives the true sign on overflow.
  function automatic logic [WIDTH-1:0] sat16(input logic [WIDTH:0] s);
    if (s[WIDTH] != s[WIDTH-1]) return s[WIDTH] ? SAT_MIN : SAT_MAX;
    return s[WIDTH-1:0];
  endfunction

  // Four independent signed nibble adds, each saturating to 0x7 / 0x8.
  function automatic logic [WIDTH-1:0] paddsb(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    logic [LANE_W:0]  s;
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      s = {x[LANE_W*i+LANE_W-1], x[LANE_W*i +: LANE_W]}
        + {y[LANE_W*i+LANE_W-1], y[LANE_W*i +: LANE_W]};
      if (s[LANE_W] != s[LANE_W-1])
        r[LANE_W*i +: LANE_W] = s[LANE_W] ? 4'h8 : 4'h7;
      else
        r[LANE_W*i +: LANE_W] = s[LANE_W-1:0];
    end
    return r;
  endfunction

  // Register stage: all state and all outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      vpend_q <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      z_out   <= 1'b0;
      n_out   <= 1'b0;
      v_out   <= 1'b0;
      en_z    <= 1'b0;
      en_n    <= 1'b0;
      en_v    <= 1'b0;
    end else begin
      state   <= state_nxt;
      op_q    <= op_nxt;
      cnt_q   <= cnt_nxt;
      acc_q   <= acc_nxt;
      vpend_q <= vpend_nxt;
      done    <= done_nxt;
      result  <= result_nxt;
      z_out   <= z_nxt;
      n_out   <= n_nxt;
      v_out   <= v_nxt;
      en_z    <= en_z_nxt;
      en_n    <= en_n_nxt;
      en_v    <= en_v_nxt;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_nxt  = state;
    op_nxt     = op_q;
    cnt_nxt    = cnt_q;
    acc_nxt    = acc_q;
    vpend_nxt  = vpend_q;
    done_nxt   = 1'b0;
    en_z_nxt   = 1'b0;
    en_n_nxt   = 1'b0;
    en_v_nxt   = 1'b0;
    result_nxt = result;
    z_nxt      = z_out;
    n_nxt      = n_out;
    v_nxt      = v_out;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          op_nxt    = opcode;
          cnt_nxt   = '0;
          vpend_nxt = 1'b0;
          case (opcode)
            OP_ADD: begin
              acc_nxt   = sat16(add_ext);
              vpend_nxt = add_ovf;
            end
            OP_SUB: begin
              acc_nxt   = sat16(sub_ext);
              vpend_nxt = sub_ovf;
            end
            OP_XOR:    acc_nxt = a ^ b;
            OP_SLL, OP_SRA, OP_ROR: begin
              acc_nxt = a;
              cnt_nxt = b[CNT_W-1:0];
            end
            OP_PADDSB: acc_nxt = paddsb(a, b);
            default:   acc_nxt = '0;
          endcase
        end
      end

      RUN: begin
        if (cnt_q != '0) begin
          cnt_nxt = cnt_q - CNT_W'(1);
          case (op_q)
            OP_SLL:  acc_nxt = {acc_q[WIDTH-2:0], 1'b0};
            OP_SRA:  acc_nxt = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
            OP_ROR:  acc_nxt = {acc_q[0], acc_q[WIDTH-1:1]};
            default: acc_nxt = acc_q;
          endcase
        end else begin
          state_nxt  = IDLE;
          done_nxt   = 1'b1;
          result_nxt = acc_q;
          case (op_q)
            OP_ADD, OP_SUB: begin
              en_z_nxt = 1'b1;
              en_n_nxt = 1'b1;
              en_v_nxt = 1'b1;
              z_nxt    = (acc_q == '0);
              n_nxt    = acc_q[WIDTH-1];
              v_nxt    = vpend_q;
            end
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
              en_z_nxt = 1'b1;
              z_nxt    = (acc_q == '0);
            end
            default: ;
          endcase
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed vector table, randomized
// operations against an arithmetic reference model, and hand-written
// sequences for busy-ignore, back-to-back accept and mid-operation reset.
module tb_alu_seq_exec;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  opcode;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        z_out;
  logic        n_out;
  logic        v_out;
  logic        en_z;
  logic        en_n;
  logic        en_v;

  int checks = 0;
  int errors = 0;

  // Flag values the flag register should currently see.
  logic mdl_z = 1'b0;
  logic mdl_n = 1'b0;
  logic mdl_v = 1'b0;

  alu_seq_exec #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .z_out(z_out), .n_out(n_out), .v_out(v_out),
    .en_z(en_z), .en_n(en_n), .en_v(en_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        z;
    logic        n;
    logic        v;
    logic [2:0]  en;   // {en_z, en_n, en_v}
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: computes result, overflow, enables and latency from
  // the operation definitions using plain integer arithmetic.
  function automatic void ref_op(input logic [3:0] op, input logic [15:0] x,
                                 input logic [15:0] y, output logic [15:0] r,
                                 output logic v, output logic [2:0] en,
                                 output int lat);
    int sx, sy, s, n, la, lb;
    logic signed [15:0] xs;
    logic signed [3:0]  nx, ny;
    sx  = int'($signed(x));
    sy  = int'($signed(y));
    n   = int'(y[3:0]);
    xs  = x;
    v   = 1'b0;
    r   = 16'h0000;
    en  = 3'b000;
    lat = 1;
    case (op)
      4'h0, 4'h1: begin
        s  = (op == 4'h0) ? sx + sy : sx - sy;
        v  = (s > 32767) || (s < -32768);
        r  = (s > 32767) ? 16'h7FFF : (s < -32768) ? 16'h8000 : 16'(s);
        en = 3'b111;
      end
      4'h2: begin r = x ^ y; en = 3'b100; end
      4'h4: begin r = 16'(32'(x) << n); en = 3'b100; lat = n + 1; end
      4'h5: begin r = 16'(xs >>> n); en = 3'b100; lat = n + 1; end
      4'h6: begin r = 16'((32'(x) >> n) | (32'(x) << (16 - n))); en = 3'b100; lat = n + 1; end
      4'h7: begin
        for (int i = 0; i < 4; i++) begin
          nx = x[4*i +: 4];
          ny = y[4*i +: 4];
          la = int'(nx);
          lb = int'(ny);
          s  = la + lb;
          if (s > 7) s = 7;
          if (s < -8) s = -8;
          r[4*i +: 4] = 4'(s);
        end
      end
      default: r = 16'h0000;
    endcase
  endfunction

  // Issue one operation from idle, wait for done (bounded), check result,
  // latency, flags and enables, then check the pulse lasts one cycle.
  task automatic run_op(input string name, input logic [3:0] op, input logic [15:0] av,
                        input logic [15:0] bv, input logic [15:0] exp_res,
                        input logic exp_z, input logic exp_n, input logic exp_v,
                        input logic [2:0] exp_en, input int exp_lat);
    int  cyc;
    logic ez, en_, ev;
    @(negedge clk);
    start = 1'b1; opcode = op; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " done seen"}, 32'(done), 32'd1);
    check({name, " latency"}, 32'(cyc), 32'(exp_lat));
    check({name, " result"}, 32'(result), 32'(exp_res));
    check({name, " enables"}, 32'({en_z, en_n, en_v}), 32'(exp_en));
    ez  = exp_en[2] ? exp_z : mdl_z;
    en_ = exp_en[1] ? exp_n : mdl_n;
    ev  = exp_en[0] ? exp_v : mdl_v;
    check({name, " flags"}, 32'({z_out, n_out, v_out}), 32'({ez, en_, ev}));
    mdl_z = ez; mdl_n = en_; mdl_v = ev;
    @(negedge clk);
    check({name, " pulse end"}, 32'({done, en_z, en_n, en_v}), 32'd0);
    check({name, " result held"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    logic [15:0] r;
    logic        v;
    logic [2:0]  en;
    int          lat, cnt_busy, cnt_done, cyc;
    logic [3:0]  op;
    logic [15:0] ra, rb;
    logic [3:0]  legal[7];

    legal = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7};

    //            op     a         b         res       z     n     v     en      lat
    vecs[0]  = '{4'h0, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1, 3'b111, 1};
    vecs[1]  = '{4'h1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0, 3'b111, 1};
    vecs[2]  = '{4'h1, 16'h8000, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1, 3'b111, 1};
    vecs[3]  = '{4'h4, 16'h0001, 16'h0004, 16'h0010, 1'b0, 1'b0, 1'b0, 3'b100, 5};
    vecs[4]  = '{4'h5, 16'h8000, 16'h000F, 16'hFFFF, 1'b0, 1'b0, 1'b0, 3'b100, 16};
    vecs[5]  = '{4'h6, 16'h0001, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b0, 3'b100, 2};
    vecs[6]  = '{4'h4, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0, 3'b100, 1};
    vecs[7]  = '{4'h7, 16'h7878, 16'h1111, 16'h7979, 1'b0, 1'b0, 1'b0, 3'b000, 1};
    vecs[8]  = '{4'h3, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 3'b000, 1};
    vecs[9]  = '{4'h2, 16'h00FF, 16'h00FF, 16'h0000, 1'b1, 1'b0, 1'b0, 3'b100, 1};
    vecs[10] = '{4'h0, 16'h8000, 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b1, 3'b111, 1};
    vecs[11] = '{4'h0, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 3'b111, 1};
    vecs[12] = '{4'h7, 16'h8888, 16'h8888, 16'h8888, 1'b0, 1'b0, 1'b0, 3'b000, 1};
    vecs[13] = '{4'h5, 16'h4000, 16'h0003, 16'h0800, 1'b0, 1'b0, 1'b0, 3'b100, 4};

    rst = 1'b1; start = 1'b0; opcode = 4'h0; a = 16'h0; b = 16'h0;
    repeat (3) @(negedge clk);
    check("reset outputs", 32'({busy, done, z_out, n_out, v_out, en_z, en_n, en_v}), 32'd0);
    check("reset result", 32'(result), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
             vecs[i].z, vecs[i].n, vecs[i].v, vecs[i].en, vecs[i].lat);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 8) < 7) op = legal[$urandom_range(0, 6)];
      else op = ($urandom_range(0, 1) == 0) ? 4'h3 : 4'($urandom_range(8, 15));
      ra = 16'($urandom);
      rb = 16'($urandom);
      ref_op(op, ra, rb, r, v, en, lat);
      run_op($sformatf("rand%0d op%h", i, op), op, ra, rb, r, (r == 16'h0), r[15], v, en, lat);
    end

    // Start held high while busy must not create extra operations.
    @(negedge clk);
    start = 1'b1; opcode = 4'h4; a = 16'h0001; b = 16'h0004;
    @(negedge clk);
    opcode = 4'h0; a = 16'h0005; b = 16'h0005;
    cnt_busy = 0; cnt_done = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 3) start = 1'b0;
      if (busy) cnt_busy++;
      if (done) begin
        cnt_done++;
        check("busy-ignore result", 32'(result), 32'h0010);
        check("busy-ignore latency", 32'(c), 32'd5);
      end
      @(negedge clk);
    end
    check("busy-ignore busy cycles", 32'(cnt_busy), 32'd5);
    check("busy-ignore done count", 32'(cnt_done), 32'd1);
    mdl_z = 1'b0;

    // Back-to-back: start on the done cycle is accepted.
    @(negedge clk);
    start = 1'b1; opcode = 4'h0; a = 16'h0001; b = 16'h0002;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 40) begin @(negedge clk); cyc++; end
    check("b2b first result", 32'(result), 32'd3);
    start = 1'b1; opcode = 4'h0; a = 16'h0003; b = 16'h0004;
    @(negedge clk);
    start = 1'b0;
    check("b2b accepted busy", 32'({busy, done}), 32'b10);
    @(negedge clk);
    check("b2b second done", 32'(done), 32'd1);
    check("b2b second result", 32'(result), 32'd7);
    check("b2b second flags", 32'({z_out, n_out, v_out, en_z, en_n, en_v}), 32'b000111);
    mdl_z = 1'b0; mdl_n = 1'b0; mdl_v = 1'b0;
    @(negedge clk);

    // Leave nonzero flags/result, then reset in the middle of a shift.
    run_op("pre-reset add", 4'h0, 16'h8000, 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b1, 3'b111, 1);
    @(negedge clk);
    start = 1'b1; opcode = 4'h4; a = 16'h0001; b = 16'h0008;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);  // count has stepped down to 3
    rst = 1'b1;
    #1;
    check("mid reset outputs", 32'({busy, done, z_out, n_out, v_out, en_z, en_n, en_v}), 32'd0);
    check("mid reset result", 32'(result), 32'd0);
    mdl_z = 1'b0; mdl_n = 1'b0; mdl_v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cnt_done = 0;
    for (int c = 0; c < 12; c++) begin
      if (done || busy || en_z || en_n || en_v) cnt_done++;
      @(negedge clk);
    end
    check("no stray activity after reset", 32'(cnt_done), 32'd0);
    run_op("post-reset add", 4'h0, 16'h0010, 16'h0020, 16'h0030, 1'b0, 1'b0, 1'b0, 3'b111, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
- Multi-cycle execute-stage ALU. Sits directly upstream of the flag register and feeds it.
- Accepts one operation per start pulse and computes a 16-bit result.
- Shifts and rotates run iteratively, one bit per cycle.
- On completion, presents Z/N/V values plus per-flag write enables for exactly one cycle, so the flag register captures them.

Parameters:
- WIDTH, 16, datapath width. Only 16 is supported; the nibble and saturation rules below assume 16.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- opcode  input  4  0000 ADD, 0001 SUB, 0010 XOR, 0100 SLL, 0101 SRA, 0110 ROR, 0111 PADDSB; all others illegal
- a  input  16  operand A, latched at accept
- b  input  16  operand B, latched at accept; b[3:0] is the shift amount for shifts
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse; result and flag outputs are valid this cycle
- result  output  16  last completed result; held between operations
- z_out  output  1  zero flag value to flag register
- n_out  output  1  negative flag value
- v_out  output  1  overflow flag value
- en_z  output  1  zero flag write enable; pulses only with done
- en_n  output  1  negative flag write enable; pulses only with done
- en_v  output  1  overflow flag write enable; pulses only with done

Behaviour:
- Reset: all outputs and internal state to 0; state IDLE. Asserting rst mid-operation aborts the operation, and no done or enable pulse is produced.
- States: IDLE, RUN. busy = (state==RUN).
- IDLE, start=1 (accept edge):
  - Latch opcode and cnt = b[3:0] if shift, else 0.
  - acc = a for shifts; for all other opcodes, acc = the computed result.
  - Go to RUN.
- RUN, cnt!=0: acc = one-bit shift of acc (SLL zero-fill, SRA sign-fill, ROR bit0→bit15); cnt--.
- RUN, cnt==0: result=acc, done=1, flag outputs/enables updated, go to IDLE.
- Latency:
  - Non-shift ops: done is high in the cycle after the accept edge (1 cycle).
  - Shift by n: done is high n+1 cycles after the accept edge. Shift by 0 returns a unchanged in 1 cycle.
- start while busy=1 is ignored; no queueing.
- Back-to-back: start is accepted in the same cycle done is high, because the state is already IDLE.
- ADD/SUB:
  - 16-bit two's-complement, saturating: positive overflow → 0x7FFF, negative overflow → 0x8000.
  - v_out = signed overflow before saturation.
  - z_out = (result==0), n_out = result[15].
  - en_z = en_n = en_v = 1.
- XOR, SLL, SRA, ROR: z_out = (result==0); en_z=1, en_n=en_v=0. n_out/v_out hold their prior values.
- PADDSB:
  - Four independent signed 4-bit lane adds, each saturating to 0x7/0x8.
  - No flag enables.
- Illegal opcode: completes in 1 cycle with result=0x0000, done=1, and no flag enables.
- done and en_* are registered outputs: high exactly one cycle, 0 otherwise.
- result and flag values hold until the next done.

Test Plan:
- ADD a=0x7FFF b=0x0001 → done 1 cycle after accept; result=0x7FFF; z=0 n=0 v=1; en_z=en_n=en_v=1 for one cycle only.
- SUB a=0x0005 b=0x0005 → result=0x0000; z=1 n=0 v=0; all three enables pulse. Then SUB a=0x8000 b=0x0001 → result=0x8000, v=1, n=1.
- SLL a=0x0001 b=0x0004 → busy high 5 cycles; done 5 cycles after accept; result=0x0010; only en_z pulses, z=0. A second start during busy produces no extra done.
- SRA a=0x8000 b=0x000F → result=0xFFFF after 16 cycles. ROR a=0x0001 b=0x0001 → result=0x8000. SLL b=0x0000 → result=a after 1 cycle.
- PADDSB a=0x7878 b=0x1111 → result=0x7979 and no enables. Opcode 0011 → done after 1 cycle, result=0x0000, no enables. A back-to-back start on the done cycle is accepted.
- Assert rst during SHIFT cnt=3 → busy, done, result, flags and enables all 0 immediately. After release, no stray done; a new ADD completes normally.
